// File: rtl/replace_num_packet_rx_pkg.sv
// -----------------------------------------------------------------------------
// replace_num_packet_rx_pkg
//   Constants shared between the replace-num UART message receiver and the
//   replace_num_mem write port: the message-type byte, the address/data field
//   widths, and helpers that split a {addr, data} packet into its fields.
// -----------------------------------------------------------------------------
package replace_num_packet_rx_pkg;

  localparam int          RN_ADDR_WIDTH  = 32'd8;
  localparam int          RN_DATA_WIDTH  = 32'd16;
  localparam logic [7:0]  RN_HEADER_BYTE = 8'h52;
  localparam int          RN_PKT_WIDTH   = RN_ADDR_WIDTH + RN_DATA_WIDTH;

  // Number of whole bytes needed to carry a packet of the given width.
  function automatic int payload_bytes(input int pkt_width);
    return (pkt_width + 32'd7) / 32'd8;
  endfunction

  // Address field of a packet; the address sits in the MSBs.
  function automatic logic [RN_ADDR_WIDTH-1:0] rn_addr(input logic [RN_PKT_WIDTH-1:0] pkt);
    return pkt[RN_PKT_WIDTH-1 -: RN_ADDR_WIDTH];
  endfunction

  // Data field of a packet; the data sits in the LSBs.
  function automatic logic [RN_DATA_WIDTH-1:0] rn_data(input logic [RN_PKT_WIDTH-1:0] pkt);
    return pkt[RN_DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/replace_num_packet_rx_uart_byte_timeout.sv
// -----------------------------------------------------------------------------
// replace_num_packet_rx_uart_byte_timeout
//   Inter-byte gap counter for the replace-num receiver.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clear      : restart the gap count (a byte arrived, or receiver is idle)
//     enable     : count idle cycles (a message is partially received)
//     expired    : this cycle is the TIMEOUT_CYCLES-th consecutive idle cycle
// -----------------------------------------------------------------------------
module replace_num_packet_rx_uart_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LIMIT    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LIMIT_M1 = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] ONE      = TW'(1);

  logic [TW-1:0] r_timer;

  // Gap counter: restarts on clear, saturates at the limit instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (clear) begin
      r_timer <= '0;
    end else if (enable && (r_timer != LIMIT)) begin
      r_timer <= r_timer + ONE;
    end else begin
      r_timer <= r_timer;
    end
  end

  // Expiry is flagged in the idle cycle that would bring the count to the
  // limit, so a byte landing in that same cycle still wins.
  assign expired = enable && !clear && (r_timer == LIMIT_M1);

endmodule

// File: rtl/replace_num_packet_rx.sv
// -----------------------------------------------------------------------------
// replace_num_packet_rx
//   Finds "replace number" messages (header, payload MSB first, XOR checksum)
//   in the UART byte stream and turns each good one into a single-cycle write
//   to replace_num_mem.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     rx_data      : byte from the UART receiver
//     rx_valid     : one-cycle strobe qualifying rx_data
//     wr_packet    : {addr, data}, held until the next good message
//     wr_en        : one-cycle write strobe
//     err_checksum : one-cycle pulse, message dropped on checksum mismatch
//     err_timeout  : one-cycle pulse, message dropped on inter-byte gap
//     busy         : a message is partially received
// -----------------------------------------------------------------------------
module replace_num_packet_rx
  import replace_num_packet_rx_pkg::*;
#(
  parameter int         ADDR_WIDTH     = RN_ADDR_WIDTH,
  parameter int         DATA_WIDTH     = RN_DATA_WIDTH,
  parameter logic [7:0] HEADER_BYTE    = RN_HEADER_BYTE,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_valid,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] wr_packet,
  output logic                             wr_en,
  output logic                             err_checksum,
  output logic                             err_timeout,
  output logic                             busy
);

  localparam int               PKT_W         = ADDR_WIDTH + DATA_WIDTH;
  localparam int               PAYLOAD_BYTES = payload_bytes(PKT_W);
  localparam int               ASM_W         = PAYLOAD_BYTES * 8;
  localparam int               CNT_W         = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX      = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  state_t           r_state,        w_state_nxt;
  logic [CNT_W-1:0] r_count,        w_count_nxt;
  logic [7:0]       r_csum,         w_csum_nxt;
  logic [ASM_W-1:0] r_asm,          w_asm_nxt;
  logic [PKT_W-1:0] r_wr_packet,    w_wr_packet_nxt;
  logic             r_wr_en,        w_wr_en_nxt;
  logic             r_err_checksum, w_err_checksum_nxt;
  logic             r_err_timeout,  w_err_timeout_nxt;

  logic w_timer_clear;
  logic w_timer_enable;
  logic w_expired;

  // The gap timer only runs mid-message; any accepted byte restarts it.
  assign w_timer_clear  = rx_valid || (r_state == S_IDLE);
  assign w_timer_enable = (r_state != S_IDLE);

  replace_num_packet_rx_uart_byte_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_timer_clear),
    .enable  (w_timer_enable),
    .expired (w_expired)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_csum         <= 8'h00;
      r_asm          <= '0;
      r_wr_packet    <= '0;
      r_wr_en        <= 1'b0;
      r_err_checksum <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_count        <= w_count_nxt;
      r_csum         <= w_csum_nxt;
      r_asm          <= w_asm_nxt;
      r_wr_packet    <= w_wr_packet_nxt;
      r_wr_en        <= w_wr_en_nxt;
      r_err_checksum <= w_err_checksum_nxt;
      r_err_timeout  <= w_err_timeout_nxt;
    end
  end

  // Next-state and output decode. Timeout is only possible on a cycle without
  // rx_valid, and wr_en/err_checksum only on one with it, so the pulses can
  // never coincide.
  always_comb begin
    w_state_nxt        = r_state;
    w_count_nxt        = r_count;
    w_csum_nxt         = r_csum;
    w_asm_nxt          = r_asm;
    w_wr_packet_nxt    = r_wr_packet;
    w_wr_en_nxt        = 1'b0;
    w_err_checksum_nxt = 1'b0;
    w_err_timeout_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid && (rx_data == HEADER_BYTE)) begin
          w_state_nxt = S_PAYLOAD;
          w_count_nxt = '0;
          w_csum_nxt  = 8'h00;
          w_asm_nxt   = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (w_expired) begin
          w_err_timeout_nxt = 1'b1;
          w_state_nxt       = S_IDLE;
        end else if (rx_valid) begin
          // MSB-first assembly; surplus top bits fall off when the packet
          // is sliced out of the assembly register.
          w_asm_nxt   = (r_asm << 4'd8) | ASM_W'(rx_data);
          w_csum_nxt  = r_csum ^ rx_data;
          w_count_nxt = r_count + CNT_ONE;
          if (r_count == LAST_IDX) begin
            w_state_nxt = S_CHECK;
          end else begin
            w_state_nxt = S_PAYLOAD;
          end
        end else begin
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_CHECK: begin
        if (w_expired) begin
          w_err_timeout_nxt = 1'b1;
          w_state_nxt       = S_IDLE;
        end else if (rx_valid) begin
          if (rx_data == r_csum) begin
            w_wr_packet_nxt = r_asm[PKT_W-1:0];
            w_wr_en_nxt     = 1'b1;
          end else begin
            w_err_checksum_nxt = 1'b1;
          end
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_CHECK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign wr_packet    = r_wr_packet;
  assign wr_en        = r_wr_en;
  assign err_checksum = r_err_checksum;
  assign err_timeout  = r_err_timeout;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_replace_num_packet_rx.sv
// -----------------------------------------------------------------------------
// tb_replace_num_packet_rx
//   Self-checking bench for replace_num_packet_rx (ADDR 8, DATA 16, timeout
//   100). Directed scenarios use literal expected values; the random scenario
//   uses a message-level reference model that walks the byte list.
// -----------------------------------------------------------------------------
module tb_replace_num_packet_rx;

  localparam int         TO  = 100;
  localparam int         P   = 3;
  localparam logic [7:0] HDR = 8'h52;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [23:0] wr_packet;
  logic        wr_en;
  logic        err_checksum;
  logic        err_timeout;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  replace_num_packet_rx #(
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (16),
    .HEADER_BYTE    (8'h52),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .wr_packet    (wr_packet),
    .wr_en        (wr_en),
    .err_checksum (err_checksum),
    .err_timeout  (err_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // ---------------- monitor (only writer of the obs_* state) ----------------
  int          cyc = 0;
  int          obs_wr = 0, obs_cs = 0, obs_to = 0, obs_busy = 0;
  int          obs_wide = 0, obs_excl = 0;
  logic        prev_wr = 1'b0, prev_cs = 1'b0, prev_to = 1'b0;
  logic [23:0] obs_pkt_q[$];
  int          obs_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_wr <= obs_wr + 1;
      obs_pkt_q.push_back(wr_packet);
      obs_cyc_q.push_back(cyc);
    end
    if (err_checksum === 1'b1) obs_cs <= obs_cs + 1;
    if (err_timeout === 1'b1) obs_to <= obs_to + 1;
    if (busy === 1'b1) obs_busy <= obs_busy + 1;
    if ((wr_en && prev_wr) || (err_checksum && prev_cs) || (err_timeout && prev_to))
      obs_wide <= obs_wide + 1;
    if ((int'(wr_en) + int'(err_checksum) + int'(err_timeout)) > 1)
      obs_excl <= obs_excl + 1;
    prev_wr <= wr_en;
    prev_cs <= err_checksum;
    prev_to <= err_timeout;
  end

  // ---------------- stimulus driver ----------------
  logic [7:0] byte_q[$];
  int         gap_q[$];
  int         byte_cyc_q[$];

  task automatic drive_stream(input int tail);
    byte_cyc_q.delete();
    for (int i = 0; i < byte_q.size(); i++) begin
      for (int g = 0; g < gap_q[i]; g++) begin
        @(posedge clk); #1;
        rx_valid = 1'b0;
      end
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = byte_q[i];
      byte_cyc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (tail) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Walks the byte list message by message: a header opens a message of P
  // payload bytes plus a checksum byte; a gap of TO or more idle cycles before
  // any of those bytes abandons the message and the late byte is re-examined
  // as if the receiver were idle.
  logic [23:0] m_pkt = 24'h0;
  logic [23:0] exp_pkt_q[$];
  int          exp_term_q[$];

  task automatic model_run(input int tail, output int n_wr, output int n_cs,
                           output int n_to, output bit busy_end);
    int          i, k, n;
    bit          done;
    logic [23:0] acc;
    logic [7:0]  x;
    n_wr = 0; n_cs = 0; n_to = 0; busy_end = 1'b0;
    exp_pkt_q.delete();
    exp_term_q.delete();
    n = byte_q.size();
    i = 0;
    while (i < n) begin
      if (byte_q[i] != HDR) begin
        i++;
        continue;
      end
      acc = 24'h0; x = 8'h00; done = 1'b0;
      for (k = 1; k <= P + 1; k++) begin
        if (i + k >= n) begin
          if (tail + 1 >= TO) n_to++;
          else busy_end = 1'b1;
          done = 1'b1;
          i = n;
          break;
        end
        if (gap_q[i + k] >= TO) begin
          n_to++;
          done = 1'b1;
          i = i + k;
          break;
        end
        if (k <= P) begin
          acc = acc * 256 + 24'(byte_q[i + k]);
          x   = x ^ byte_q[i + k];
        end else if (byte_q[i + k] == x) begin
          n_wr++;
          m_pkt = acc;
          exp_pkt_q.push_back(acc);
          exp_term_q.push_back(i + k);
        end else begin
          n_cs++;
        end
      end
      if (!done) i = i + P + 2;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else n_pass++;
    n_checks++; if (err_checksum !== 1'b0) $display("FAIL reset_err_cs: got %b want 0", err_checksum); else n_pass++;
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL reset_err_to: got %b want 0", err_timeout); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (wr_packet !== 24'h0) $display("FAIL reset_pkt: got %h want 000000", wr_packet); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_good_message();
    int s_wr, s_cs, s_to, s_pk, got_c;
    logic [23:0] got_p;
    s_wr = obs_wr; s_cs = obs_cs; s_to = obs_to; s_pk = obs_pkt_q.size();
    byte_q = '{8'h52, 8'h05, 8'h12, 8'h34, 8'h23};
    gap_q  = '{0, 0, 0, 0, 0};
    drive_stream(3);
    got_p = (obs_pkt_q.size() > s_pk) ? obs_pkt_q[s_pk] : 24'h0;
    got_c = (obs_cyc_q.size() > s_pk) ? obs_cyc_q[s_pk] : -1;
    n_checks++; if (obs_wr - s_wr !== 1) $display("FAIL good_wr_count: got %0d want 1", obs_wr - s_wr); else n_pass++;
    n_checks++; if (got_p !== 24'h051234) $display("FAIL good_pkt: got %h want 051234", got_p); else n_pass++;
    n_checks++; if (got_c !== byte_cyc_q[4] + 1) $display("FAIL good_latency: got cycle %0d want %0d", got_c, byte_cyc_q[4] + 1); else n_pass++;
    n_checks++; if ((obs_cs - s_cs) + (obs_to - s_to) !== 0) $display("FAIL good_errors: got %0d want 0", (obs_cs - s_cs) + (obs_to - s_to)); else n_pass++;
    n_checks++; if (wr_packet !== 24'h051234) $display("FAIL good_pkt_hold: got %h want 051234", wr_packet); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL good_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_bad_checksum();
    int s_wr, s_cs, s_to;
    s_wr = obs_wr; s_cs = obs_cs; s_to = obs_to;
    byte_q = '{8'h52, 8'h05, 8'h12, 8'h34, 8'h24};
    gap_q  = '{0, 0, 0, 0, 0};
    drive_stream(3);
    n_checks++; if (obs_cs - s_cs !== 1) $display("FAIL badcs_err_cs: got %0d want 1", obs_cs - s_cs); else n_pass++;
    n_checks++; if (obs_wr - s_wr !== 0) $display("FAIL badcs_wr: got %0d want 0", obs_wr - s_wr); else n_pass++;
    n_checks++; if (obs_to - s_to !== 0) $display("FAIL badcs_err_to: got %0d want 0", obs_to - s_to); else n_pass++;
    n_checks++; if (wr_packet !== 24'h051234) $display("FAIL badcs_pkt_kept: got %h want 051234", wr_packet); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL badcs_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_noise();
    int s_wr, s_cs, s_to, s_busy, s_pk;
    logic [23:0] got_p;
    s_wr = obs_wr; s_cs = obs_cs; s_to = obs_to; s_busy = obs_busy;
    byte_q = '{8'h41, 8'h00, 8'hFF};
    gap_q  = '{0, 0, 0};
    drive_stream(2);
    n_checks++; if (obs_busy - s_busy !== 0) $display("FAIL noise_busy_cycles: got %0d want 0", obs_busy - s_busy); else n_pass++;
    n_checks++; if ((obs_cs - s_cs) + (obs_to - s_to) + (obs_wr - s_wr) !== 0) $display("FAIL noise_events: got %0d want 0", (obs_cs - s_cs) + (obs_to - s_to) + (obs_wr - s_wr)); else n_pass++;
    s_pk = obs_pkt_q.size();
    byte_q = '{8'h52, 8'h05, 8'h12, 8'h34, 8'h23};
    gap_q  = '{0, 0, 0, 0, 0};
    drive_stream(3);
    got_p = (obs_pkt_q.size() > s_pk) ? obs_pkt_q[s_pk] : 24'h0;
    n_checks++; if (obs_wr - s_wr !== 1) $display("FAIL noise_wr_count: got %0d want 1", obs_wr - s_wr); else n_pass++;
    n_checks++; if (got_p !== 24'h051234) $display("FAIL noise_pkt: got %h want 051234", got_p); else n_pass++;
    n_checks++; if ((obs_cs - s_cs) + (obs_to - s_to) !== 0) $display("FAIL noise_msg_errors: got %0d want 0", (obs_cs - s_cs) + (obs_to - s_to)); else n_pass++;
  endtask

  task automatic test_timeout();
    int s_wr, s_cs, s_to;
    s_wr = obs_wr; s_cs = obs_cs; s_to = obs_to;
    byte_q = '{8'h52, 8'h05, 8'h52, 8'hAA, 8'h00, 8'h01, 8'hAB};
    gap_q  = '{0, 0, TO, 0, 0, 0, 0};
    drive_stream(3);
    n_checks++; if (obs_to - s_to !== 1) $display("FAIL to_err_to: got %0d want 1", obs_to - s_to); else n_pass++;
    n_checks++; if (obs_wr - s_wr !== 1) $display("FAIL to_wr_after: got %0d want 1", obs_wr - s_wr); else n_pass++;
    n_checks++; if (wr_packet !== 24'hAA0001) $display("FAIL to_pkt_after: got %h want AA0001", wr_packet); else n_pass++;
    n_checks++; if (obs_cs - s_cs !== 0) $display("FAIL to_err_cs: got %0d want 0", obs_cs - s_cs); else n_pass++;
    // One idle cycle short of the limit: the message must survive.
    s_wr = obs_wr; s_to = obs_to;
    byte_q = '{8'h52, 8'h05, 8'h12, 8'h34, 8'h23};
    gap_q  = '{0, 0, TO - 1, 0, 0};
    drive_stream(3);
    n_checks++; if (obs_to - s_to !== 0) $display("FAIL edge_err_to: got %0d want 0", obs_to - s_to); else n_pass++;
    n_checks++; if (obs_wr - s_wr !== 1) $display("FAIL edge_wr: got %0d want 1", obs_wr - s_wr); else n_pass++;
    n_checks++; if (wr_packet !== 24'h051234) $display("FAIL edge_pkt: got %h want 051234", wr_packet); else n_pass++;
  endtask

  task automatic test_reset_mid_message();
    int s_wr, s_cs, s_to;
    s_wr = obs_wr; s_cs = obs_cs; s_to = obs_to;
    byte_q = '{8'h52, 8'h05};
    gap_q  = '{0, 0};
    drive_stream(0);
    n_checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy); else n_pass++;
    apply_reset(2);
    byte_q = '{8'h12, 8'h34, 8'h23};
    gap_q  = '{0, 0, 0};
    drive_stream(3);
    n_checks++; if (obs_wr - s_wr !== 0) $display("FAIL rstmid_wr: got %0d want 0", obs_wr - s_wr); else n_pass++;
    n_checks++; if ((obs_cs - s_cs) + (obs_to - s_to) !== 0) $display("FAIL rstmid_errors: got %0d want 0", (obs_cs - s_cs) + (obs_to - s_to)); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (wr_packet !== 24'h0) $display("FAIL rstmid_pkt: got %h want 000000", wr_packet); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s_wr, s_wide, s_pk, got_c;
    logic [23:0] got_p;
    logic [23:0] want_p[2];
    int          want_t[2];
    want_p[0] = 24'h051234; want_p[1] = 24'hAA0001;
    want_t[0] = 4;          want_t[1] = 9;
    s_wr = obs_wr; s_wide = obs_wide; s_pk = obs_pkt_q.size();
    byte_q = '{8'h52, 8'h05, 8'h12, 8'h34, 8'h23, 8'h52, 8'hAA, 8'h00, 8'h01, 8'hAB};
    gap_q  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive_stream(3);
    n_checks++; if (obs_wr - s_wr !== 2) $display("FAIL b2b_wr_count: got %0d want 2", obs_wr - s_wr); else n_pass++;
    n_checks++; if (obs_wide - s_wide !== 0) $display("FAIL b2b_pulse_width: got %0d wide pulses want 0", obs_wide - s_wide); else n_pass++;
    for (int m = 0; m < 2; m++) begin
      got_p = (obs_pkt_q.size() > s_pk + m) ? obs_pkt_q[s_pk + m] : 24'h0;
      got_c = (obs_cyc_q.size() > s_pk + m) ? obs_cyc_q[s_pk + m] : -1;
      n_checks++; if (got_p !== want_p[m]) $display("FAIL b2b_pkt%0d: got %h want %h", m, got_p, want_p[m]); else n_pass++;
      n_checks++; if (got_c !== byte_cyc_q[want_t[m]] + 1) $display("FAIL b2b_latency%0d: got %0d want %0d", m, got_c, byte_cyc_q[want_t[m]] + 1); else n_pass++;
    end
  endtask

  task automatic test_random();
    int          s_wr, s_cs, s_to, s_wide, s_excl, s_pk, got_c;
    int          e_wr, e_cs, e_to;
    bit          e_busy;
    logic [23:0] got_p;
    logic [7:0]  pl[3];
    logic [7:0]  x;
    int          kind;
    apply_reset(2);
    m_pkt = 24'h0;
    for (int round = 0; round < 6; round++) begin
      byte_q.delete();
      gap_q.delete();
      for (int seg = 0; seg < 6; seg++) begin
        kind = $urandom_range(0, 9);
        if (kind >= 7 && kind <= 8) begin
          byte_q.push_back(8'($urandom_range(0, 255)));
        end else begin
          for (int b = 0; b < 3; b++) pl[b] = 8'($urandom_range(0, 255));
          x = pl[0] ^ pl[1] ^ pl[2];
          byte_q.push_back(HDR);
          for (int b = 0; b < ((kind == 9) ? int'($urandom_range(1, 3)) : 3); b++) byte_q.push_back(pl[b]);
          if (kind <= 4) byte_q.push_back(x);
          else if (kind <= 6) byte_q.push_back(x ^ 8'(1 << $urandom_range(0, 7)));
        end
      end
      for (int i = 0; i < byte_q.size(); i++)
        gap_q.push_back(($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 2, TO + 1)) : int'($urandom_range(0, 2)));
      model_run(105, e_wr, e_cs, e_to, e_busy);
      s_wr = obs_wr; s_cs = obs_cs; s_to = obs_to; s_wide = obs_wide; s_excl = obs_excl;
      s_pk = obs_pkt_q.size();
      drive_stream(105);
      n_checks++; if (obs_wr - s_wr !== e_wr) $display("FAIL rnd%0d_wr: got %0d want %0d", round, obs_wr - s_wr, e_wr); else n_pass++;
      n_checks++; if (obs_cs - s_cs !== e_cs) $display("FAIL rnd%0d_err_cs: got %0d want %0d", round, obs_cs - s_cs, e_cs); else n_pass++;
      n_checks++; if (obs_to - s_to !== e_to) $display("FAIL rnd%0d_err_to: got %0d want %0d", round, obs_to - s_to, e_to); else n_pass++;
      n_checks++; if (busy !== e_busy) $display("FAIL rnd%0d_busy: got %b want %b", round, busy, e_busy); else n_pass++;
      n_checks++; if (wr_packet !== m_pkt) $display("FAIL rnd%0d_pkt_hold: got %h want %h", round, wr_packet, m_pkt); else n_pass++;
      n_checks++; if ((obs_wide - s_wide) + (obs_excl - s_excl) !== 0) $display("FAIL rnd%0d_pulse_shape: got %0d bad cycles want 0", round, (obs_wide - s_wide) + (obs_excl - s_excl)); else n_pass++;
      for (int m = 0; m < exp_pkt_q.size(); m++) begin
        got_p = (obs_pkt_q.size() > s_pk + m) ? obs_pkt_q[s_pk + m] : 24'h0;
        got_c = (obs_cyc_q.size() > s_pk + m) ? obs_cyc_q[s_pk + m] : -1;
        n_checks++; if (got_p !== exp_pkt_q[m]) $display("FAIL rnd%0d_pkt%0d: got %h want %h", round, m, got_p, exp_pkt_q[m]); else n_pass++;
        n_checks++; if (got_c !== byte_cyc_q[exp_term_q[m]] + 1) $display("FAIL rnd%0d_lat%0d: got %0d want %0d", round, m, got_c, byte_cyc_q[exp_term_q[m]] + 1); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_message();
    test_bad_checksum();
    test_noise();
    test_timeout();
    test_reset_mid_message();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop so the run always ends even if stimulus stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
